// File: rtl/hive_reg_spi_slv.sv
// SPI mode-0 slave with one-byte RX and TX buffers, exposed on the rbus as
// STATUS / RX_DATA / TX_DATA.
module hive_reg_spi_slv #(
  parameter int RBUS_ADDR_W = 4,
  parameter int ALU_W       = 32,
  parameter int SYNC_W      = 2,
  parameter int BASE_ADDR   = 'h8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o,
  input  logic                   scl_i,
  input  logic                   scs_i,
  input  logic                   sdi_i,
  output logic                   sdo_o,
  output logic                   sdo_oe_o
);

  localparam logic [RBUS_ADDR_W-1:0] STATUS_ADDR = RBUS_ADDR_W'(BASE_ADDR);
  localparam logic [RBUS_ADDR_W-1:0] RX_ADDR     = RBUS_ADDR_W'(BASE_ADDR + 1);
  localparam logic [RBUS_ADDR_W-1:0] TX_ADDR     = RBUS_ADDR_W'(BASE_ADDR + 2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [7:0]        rx_buf;
  logic [7:0]        tx_buf;
  logic              rx_vld;
  logic              tx_full;
  logic              ovr;
  logic              udr;

  logic [SYNC_W-1:0] scl_sync;
  logic [SYNC_W-1:0] scs_sync;
  logic [SYNC_W-1:0] sdi_sync;
  logic              scl_prev;
  logic              scs_prev;
  logic [SYNC_W:0]   arm_q;

  logic scl_s, scs_s, sdi_s;
  logic scl_rise, scl_fall, scs_rise, scs_fall;
  logic st_rd, rx_rd, st_wr, tx_wr;
  logic frame_start, in_frame, tx_load, byte_done;
  logic [7:0] load_byte;
  logic [7:0] rx_next;
  logic       unused_bits;

  // Pin synchronizers. arm_q fills with ones once the whole chain holds real
  // pin samples, so a chip select held low through reset never looks like a
  // fresh falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '0;
      scs_sync <= '1;
      sdi_sync <= '0;
      scl_prev <= 1'b0;
      scs_prev <= 1'b1;
      arm_q    <= '0;
    end else begin
      scl_sync <= SYNC_W'({scl_sync, scl_i});
      scs_sync <= SYNC_W'({scs_sync, scs_i});
      sdi_sync <= SYNC_W'({sdi_sync, sdi_i});
      scl_prev <= scl_s;
      scs_prev <= scs_s;
      arm_q    <= {arm_q[SYNC_W-1:0], 1'b1};
    end
  end

  assign scl_s    = scl_sync[SYNC_W-1];
  assign scs_s    = scs_sync[SYNC_W-1];
  assign sdi_s    = sdi_sync[SYNC_W-1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign scs_rise = scs_s & ~scs_prev;
  assign scs_fall = ~scs_s & scs_prev & arm_q[SYNC_W];

  assign st_rd = rbus_rd_i && (rbus_addr_i == STATUS_ADDR);
  assign rx_rd = rbus_rd_i && (rbus_addr_i == RX_ADDR);
  assign st_wr = rbus_wr_i && (rbus_addr_i == STATUS_ADDR);
  assign tx_wr = rbus_wr_i && (rbus_addr_i == TX_ADDR);

  // A chip-select rise outranks a coincident scl edge, so a master that drops
  // scl together with scs at the end of a frame does not trigger a reload.
  assign frame_start = (state == IDLE) && scs_fall;
  assign in_frame    = (state == ACTIVE) && !scs_rise;
  assign tx_load     = frame_start || (in_frame && scl_fall && (bit_cnt == 3'd0));
  assign byte_done   = in_frame && scl_rise && (bit_cnt == 3'd7);
  assign load_byte   = tx_full ? tx_buf : 8'h00;
  assign rx_next     = {rx_shift, sdi_s};

  assign unused_bits = &{1'b0, rbus_wr_data_i[ALU_W-1:8], tx_shift[7]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      sdo_o    <= 1'b0;
      sdo_oe_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= 3'd0;
            tx_shift <= load_byte;
            sdo_o    <= load_byte[7];
            sdo_oe_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (scs_rise) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            sdo_o    <= 1'b0;
            sdo_oe_o <= 1'b0;
          end else if (scl_rise) begin
            rx_shift <= rx_next[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              tx_shift <= load_byte;
              sdo_o    <= load_byte[7];
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              sdo_o    <= tx_shift[6];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_buf         <= 8'd0;
      tx_buf         <= 8'd0;
      rx_vld         <= 1'b0;
      tx_full        <= 1'b0;
      ovr            <= 1'b0;
      udr            <= 1'b0;
      rbus_rd_data_o <= '0;
    end else begin
      if (st_wr && rbus_wr_data_i[2]) ovr <= 1'b0;
      if (st_wr && rbus_wr_data_i[3]) udr <= 1'b0;

      if (tx_load) begin
        tx_full <= 1'b0;
        if (!tx_full) udr <= 1'b1;
      end
      // A write landing with a load still wins: the old byte was shifted out.
      if (tx_wr) begin
        tx_buf  <= rbus_wr_data_i[7:0];
        tx_full <= 1'b1;
      end

      if (byte_done) begin
        if (rx_vld && !rx_rd) begin
          ovr <= 1'b1;
        end else begin
          rx_buf <= rx_next;
          rx_vld <= 1'b1;
        end
      end else if (rx_rd) begin
        rx_vld <= 1'b0;
      end

      rbus_rd_data_o <= '0;
      if (st_rd)
        rbus_rd_data_o <= {{(ALU_W-5){1'b0}}, (state == ACTIVE), udr, ovr, ~tx_full, rx_vld};
      else if (rx_rd)
        rbus_rd_data_o <= {{(ALU_W-8){1'b0}}, rx_buf};
    end
  end

endmodule

// File: tb/tb_hive_reg_spi_slv.sv
// Self-checking bench for hive_reg_spi_slv: a bit-banged SPI master and rbus
// driver, checked against a transaction-level model of the register block.
module tb_hive_reg_spi_slv;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int HALF = 8;
  localparam logic [AW-1:0] A_ST = 4'h8;
  localparam logic [AW-1:0] A_RX = 4'h9;
  localparam logic [AW-1:0] A_TX = 4'hA;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rbus_addr = '0;
  logic          rbus_wr = 1'b0;
  logic          rbus_rd = 1'b0;
  logic [DW-1:0] rbus_wr_data = '0;
  logic [DW-1:0] rbus_rd_data;
  logic          scl = 1'b0;
  logic          scs = 1'b1;
  logic          sdi = 1'b0;
  logic          sdo;
  logic          sdo_oe;

  hive_reg_spi_slv dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rbus_addr_i    (rbus_addr),
    .rbus_wr_i      (rbus_wr),
    .rbus_rd_i      (rbus_rd),
    .rbus_wr_data_i (rbus_wr_data),
    .rbus_rd_data_o (rbus_rd_data),
    .scl_i          (scl),
    .scs_i          (scs),
    .sdi_i          (sdi),
    .sdo_o          (sdo),
    .sdo_oe_o       (sdo_oe)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, updated per transaction
  logic       m_rx_vld = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;
  logic       m_ovr = 1'b0;
  logic       m_udr = 1'b0;
  logic       m_tx_full = 1'b0;
  logic [7:0] m_tx_buf = 8'h00;

  logic [7:0] mosi_arr[4];
  logic       oe_seen;
  logic [31:0] rd_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_load();
    logic [7:0] b;
    if (m_tx_full) b = m_tx_buf;
    else begin
      b = 8'h00;
      m_udr = 1'b1;
    end
    m_tx_full = 1'b0;
    return b;
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (m_rx_vld) m_ovr = 1'b1;
    else begin
      m_rx_byte = b;
      m_rx_vld  = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_status();
    return {27'd0, 1'b0, m_udr, m_ovr, ~m_tx_full, m_rx_vld};
  endfunction

  function automatic void model_reset();
    m_rx_vld = 1'b0; m_rx_byte = 8'h00; m_ovr = 1'b0;
    m_udr = 1'b0; m_tx_full = 1'b0; m_tx_buf = 8'h00;
  endfunction

  // rbus driver tasks (all start and end on a falling clock edge)
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rbus_addr = a; rbus_wr_data = d; rbus_wr = 1'b1;
    @(negedge clk);
    rbus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    rbus_addr = a; rbus_rd = 1'b1;
    @(negedge clk);
    rbus_rd = 1'b0;
    d = rbus_rd_data;
    @(negedge clk);
    check("rd_idle", rbus_rd_data, 32'h0);
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(A_TX, {24'h0, b});
    m_tx_buf = b; m_tx_full = 1'b1;
  endtask

  task automatic status_write(input logic [3:0] v);
    bus_write(A_ST, {28'h0, v});
    if (v[2]) m_ovr = 1'b0;
    if (v[3]) m_udr = 1'b0;
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    bus_read(A_ST, d);
    check(tag, d, model_status());
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    bus_read(A_RX, d);
    check(tag, d, {24'h0, m_rx_byte});
    m_rx_vld = 1'b0;
  endtask

  // SPI master: sdi changes with scl low, MISO sampled just before scl rises
  task automatic spi_bit(input logic b, input bit last, output logic miso);
    sdi = b;
    repeat (HALF) @(negedge clk);
    miso = sdo;
    oe_seen = sdo_oe;
    scl = 1'b1;
    repeat (HALF) @(negedge clk);
    scl = 1'b0;
    if (last) scs = 1'b1;
  endtask

  task automatic spi_frame(input int n);
    logic [7:0] exp, got;
    logic bitv;
    scs = 1'b0;
    exp = model_load();
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_bit(mosi_arr[k][i], (k == n - 1) && (i == 0), bitv);
        got[i] = bitv;
      end
      check("miso_byte", {24'h0, got}, {24'h0, exp});
      check("sdo_oe_active", {31'h0, oe_seen}, 32'h1);
      model_rx(mosi_arr[k]);
      if (k < n - 1) exp = model_load();
    end
    repeat (HALF) @(negedge clk);
    check("sdo_oe_idle", {31'h0, sdo_oe}, 32'h0);
    check("sdo_idle", {31'h0, sdo}, 32'h0);
  endtask

  task automatic spi_partial(input int nbits);
    logic [7:0] exp;
    logic bitv;
    scs = 1'b0;
    exp = model_load();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi_arr[0][7-i], i == nbits - 1, bitv);
      check("miso_partial", {31'h0, bitv}, {31'h0, exp[7-i]});
    end
    repeat (HALF) @(negedge clk);
  endtask

  // last rising scl of the byte is timed so the RX_DATA read strobe lands in
  // the same clock as the byte completion (pin edge + 3 clocks)
  task automatic same_cycle_read(input logic [7:0] b);
    logic [7:0] exp, got;
    logic bitv;
    logic [31:0] d;
    scs = 1'b0;
    exp = model_load();
    for (int i = 7; i >= 1; i--) begin
      spi_bit(b[i], 1'b0, bitv);
      got[i] = bitv;
    end
    sdi = b[0];
    repeat (HALF) @(negedge clk);
    got[0] = sdo;
    scl = 1'b1;
    repeat (2) @(negedge clk);
    rbus_addr = A_RX; rbus_rd = 1'b1;
    @(negedge clk);
    rbus_rd = 1'b0;
    d = rbus_rd_data;
    check("rx_same_cycle", d, {24'h0, m_rx_byte});
    check("miso_same_cycle", {24'h0, got}, {24'h0, exp});
    m_rx_byte = b; m_rx_vld = 1'b1;
    repeat (HALF - 3) @(negedge clk);
    scl = 1'b0; scs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bitv;
    repeat (3) @(negedge clk);
    check("rst_rd_data", rbus_rd_data, 32'h0);
    check("rst_sdo", {31'h0, sdo}, 32'h0);
    check("rst_sdo_oe", {31'h0, sdo_oe}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    read_status("status_after_reset");

    // TX 0xA5 out while 0x3C comes in
    tx_write(8'hA5);
    read_status("status_tx_full");
    mosi_arr[0] = 8'h3C;
    spi_frame(1);
    read_status("status_after_byte");
    read_rx("rx_3c");
    read_status("status_after_rx_read");

    // underrun, then clear it through STATUS
    mosi_arr[0] = 8'h77;
    spi_frame(1);
    read_status("status_udr");
    status_write(4'h8);
    read_status("status_udr_cleared");
    read_rx("rx_77");

    // two bytes without reading RX -> overrun keeps the first
    tx_write(8'h96);
    mosi_arr[0] = 8'h11; mosi_arr[1] = 8'h22;
    spi_frame(2);
    read_status("status_ovr");
    read_rx("rx_11");
    status_write(4'h4);
    read_status("status_ovr_cleared");

    // aborted partial byte, then a full byte
    mosi_arr[0] = 8'hFF;
    spi_partial(5);
    read_status("status_after_partial");
    mosi_arr[0] = 8'h81;
    spi_frame(1);
    read_status("status_after_81");
    read_rx("rx_81");
    status_write(4'hC);

    // RX read colliding with completion of the next byte
    mosi_arr[0] = 8'h5A;
    spi_frame(1);
    same_cycle_read(8'hC3);
    read_status("status_same_cycle");
    read_rx("rx_c3");
    status_write(4'hC);

    // unmapped addresses read as zero
    bus_read(4'h0, rd_val);
    check("rd_unmapped_0", rd_val, 32'h0);
    bus_read(4'hF, rd_val);
    check("rd_unmapped_f", rd_val, 32'h0);
    rbus_addr = A_ST;
    @(negedge clk);
    check("rd_strobe_low", rbus_rd_data, 32'h0);

    // reset mid-frame with chip select held low throughout
    tx_write(8'h3E);
    mosi_arr[0] = 8'hB4;
    scs = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(mosi_arr[0][7-i], 1'b0, bitv);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sdo", {31'h0, sdo}, 32'h0);
    check("midrst_sdo_oe", {31'h0, sdo_oe}, 32'h0);
    check("midrst_rd_data", rbus_rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    check("held_cs_sdo_oe", {31'h0, sdo_oe}, 32'h0);
    read_status("status_held_cs");
    scs = 1'b1;
    repeat (HALF) @(negedge clk);
    mosi_arr[0] = 8'h42;
    spi_frame(1);
    read_rx("rx_after_reset");

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom_range(0, 255)));
      for (int k = 0; k < 4; k++) mosi_arr[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) spi_partial(int'($urandom_range(1, 7)));
      else spi_frame(int'($urandom_range(1, 3)));
      read_status("rnd_status");
      if ($urandom_range(0, 2) != 0) read_rx("rnd_rx");
      if ($urandom_range(0, 1) == 1) status_write(4'($urandom_range(0, 15)));
    end
    read_status("final_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
